// File: rtl/semaforo_pkg.sv
// Shared types and helpers for the multi-approach traffic-light controller.
package semaforo_pkg;

    typedef enum logic [2:0] {
        TODO_ROJO,
        VERDE,
        AMARILLO,
        BLANCO,
        NOCHE
    } estado_t;

    // Lamp set for a single vehicle approach.
    typedef struct packed {
        logic rojo;
        logic amarillo;
        logic verde;
    } lampara_t;

    // Timer width: enough bits to hold the longest state duration.
    function automatic int ancho_timer(input int t0, input int t1, input int t2, input int t3);
        int m;
        m = t0;
        if (t1 > m) m = t1;
        if (t2 > m) m = t2;
        if (t3 > m) m = t3;
        return $clog2(m + 1);
    endfunction

    // Lamp encoding of one approach given the state, whether it is the
    // approach being served, and the night flash phase.
    function automatic lampara_t lampara(input estado_t e, input logic activa, input logic fase);
        lampara_t l;
        l = '{rojo: 1'b1, amarillo: 1'b0, verde: 1'b0};
        case (e)
            VERDE:    if (activa) l = '{rojo: 1'b0, amarillo: 1'b0, verde: 1'b1};
            AMARILLO: if (activa) l = '{rojo: 1'b0, amarillo: 1'b1, verde: 1'b0};
            NOCHE:    l = '{rojo: 1'b0, amarillo: fase, verde: 1'b0};
            default:  ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/semaforo_multi_antirrebote.sv
// Push-button conditioner: 2-FF synchroniser, stable-high counter and a
// single-cycle press pulse. The button must drop before another press counts.
module antirrebote #(
    parameter int DEB_CICLOS = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic entrada_i,
    output logic pulso_o
);

    localparam int CW = $clog2(DEB_CICLOS + 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hecho_q, hecho_d;
    logic          pulso_q, pulso_d;

    // Synchroniser, stability counter and pulse register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            hecho_q <= 1'b0;
            pulso_q <= 1'b0;
        end else begin
            sync1_q <= entrada_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            hecho_q <= hecho_d;
            pulso_q <= pulso_d;
        end
    end

    // Count consecutive high cycles; fire once, then wait for release.
    always_comb begin
        cnt_d   = cnt_q;
        hecho_d = hecho_q;
        pulso_d = 1'b0;
        if (!sync2_q) begin
            cnt_d   = '0;
            hecho_d = 1'b0;
        end else if (!hecho_q) begin
            if (cnt_q == CW'(DEB_CICLOS - 1)) begin
                pulso_d = 1'b1;
                hecho_d = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign pulso_o = pulso_q;

endmodule

// File: rtl/semaforo_multi.sv
// Round-robin traffic-light controller with pedestrian walk phase and
// flashing-amber night mode. All state timing runs on prescaled ticks.
module semaforo_multi
    import semaforo_pkg::*;
#(
    parameter int N_VIAS      = 2,
    parameter int TICK_DIV    = 4,
    parameter int T_VERDE     = 8,
    parameter int T_VERDE_MIN = 3,
    parameter int T_AMARILLO  = 2,
    parameter int T_ROJO      = 1,
    parameter int T_BLANCO    = 5,
    parameter int DEB_CICLOS  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pulsador,
    input  logic                      modo_noche,
    output logic [N_VIAS-1:0]         rojo,
    output logic [N_VIAS-1:0]         amarillo,
    output logic [N_VIAS-1:0]         verde,
    output logic                      blanco,
    output logic [$clog2(N_VIAS)-1:0] via_activa
);

    localparam int VW = $clog2(N_VIAS);
    localparam int TW = ancho_timer(T_VERDE, T_AMARILLO, T_ROJO, T_BLANCO);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]     pre_q;
    logic              tick;
    logic              noche_s1_q, noche_s2_q;
    logic              pulso;
    estado_t           estado_q, estado_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [VW-1:0]     via_q, via_d, via_sig;
    logic              primero_q, primero_d;
    logic              fase_q, fase_d;
    logic              peticion_q, peticion_d;
    logic              verde_min_ok;
    logic [N_VIAS-1:0] rojo_q, amarillo_q, verde_q;
    logic [N_VIAS-1:0] rojo_d, amarillo_d, verde_d;
    logic              blanco_q;
    logic [VW-1:0]     via_act_q;
    lampara_t          l;

    antirrebote #(.DEB_CICLOS(DEB_CICLOS)) u_antirrebote (
        .clk      (clk),
        .rst      (rst),
        .entrada_i(pulsador),
        .pulso_o  (pulso)
    );

    // Free-running prescaler; the FSM never restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pre_q <= '0;
        else      pre_q <= (pre_q == PW'(TICK_DIV - 1)) ? '0 : pre_q + PW'(1);
    end

    assign tick = (pre_q == PW'(TICK_DIV - 1));

    // Night-mode request synchroniser.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            noche_s1_q <= 1'b0;
            noche_s2_q <= 1'b0;
        end else begin
            noche_s1_q <= modo_noche;
            noche_s2_q <= noche_s1_q;
        end
    end

    assign via_sig      = (via_q == VW'(N_VIAS - 1)) ? '0 : via_q + VW'(1);
    // True when this tick completes at least T_VERDE_MIN green ticks.
    assign verde_min_ok = (timer_q <= TW'(T_VERDE - T_VERDE_MIN + 1));

    // FSM state, timer, approach index and request latch registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q   <= TODO_ROJO;
            timer_q    <= TW'(T_ROJO);
            via_q      <= '0;
            primero_q  <= 1'b1;
            fase_q     <= 1'b0;
            peticion_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            timer_q    <= timer_d;
            via_q      <= via_d;
            primero_q  <= primero_d;
            fase_q     <= fase_d;
            peticion_q <= peticion_d;
        end
    end

    // Next state: every transition happens on a tick; timer is reloaded on entry.
    always_comb begin
        estado_d  = estado_q;
        timer_d   = timer_q;
        via_d     = via_q;
        primero_d = primero_q;
        fase_d    = fase_q;
        if (tick) begin
            case (estado_q)
                TODO_ROJO: begin
                    if (timer_q == TW'(1)) begin
                        if (noche_s2_q) begin
                            estado_d = NOCHE;
                            fase_d   = 1'b1;
                        end else if (peticion_q) begin
                            estado_d = BLANCO;
                            timer_d  = TW'(T_BLANCO);
                        end else begin
                            estado_d  = VERDE;
                            timer_d   = TW'(T_VERDE);
                            via_d     = primero_q ? '0 : via_sig;
                            primero_d = 1'b0;
                        end
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                VERDE: begin
                    if (timer_q == TW'(1) || (verde_min_ok && (peticion_q || noche_s2_q))) begin
                        estado_d = AMARILLO;
                        timer_d  = TW'(T_AMARILLO);
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                AMARILLO, BLANCO: begin
                    if (timer_q == TW'(1)) begin
                        estado_d = TODO_ROJO;
                        timer_d  = TW'(T_ROJO);
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                NOCHE: begin
                    if (!noche_s2_q) begin
                        estado_d  = TODO_ROJO;
                        timer_d   = TW'(T_ROJO);
                        primero_d = 1'b1;
                    end else begin
                        fase_d = ~fase_q;
                    end
                end
                default: begin
                    estado_d = TODO_ROJO;
                    timer_d  = TW'(T_ROJO);
                end
            endcase
        end
    end

    // Request latch: clearing on entry to the walk phase beats a same-cycle press.
    always_comb begin
        peticion_d = peticion_q;
        if (estado_d == BLANCO && estado_q != BLANCO)
            peticion_d = 1'b0;
        else if (pulso && estado_q != BLANCO && estado_q != NOCHE)
            peticion_d = 1'b1;
    end

    // Per-approach lamp decode from the current state.
    always_comb begin
        rojo_d     = '0;
        amarillo_d = '0;
        verde_d    = '0;
        l          = '0;
        for (int i = 0; i < N_VIAS; i++) begin
            l             = lampara(estado_q, via_q == VW'(i), fase_q);
            rojo_d[i]     = l.rojo;
            amarillo_d[i] = l.amarillo;
            verde_d[i]    = l.verde;
        end
    end

    // Registered lamp drivers, one cycle behind the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rojo_q     <= '1;
            amarillo_q <= '0;
            verde_q    <= '0;
            blanco_q   <= 1'b0;
            via_act_q  <= '0;
        end else begin
            rojo_q     <= rojo_d;
            amarillo_q <= amarillo_d;
            verde_q    <= verde_d;
            blanco_q   <= (estado_q == BLANCO);
            via_act_q  <= via_q;
        end
    end

    assign rojo       = rojo_q;
    assign amarillo   = amarillo_q;
    assign verde      = verde_q;
    assign blanco     = blanco_q;
    assign via_activa = via_act_q;

endmodule

// File: doc/semaforo_multi.md
Name: semaforo_multi

Overview:
Parametrised traffic-light controller, successor to the single-approach semaforo.
- Serves N_VIAS vehicle approaches in round-robin green order.
- Has one debounced pedestrian push-button with request latch, and a pedestrian walk phase (blanco).
- Supports early green termination on pedestrian demand and a night mode with flashing amber.
- Sits between board push-button/switch inputs and lamp drivers; all timing is in prescaled ticks.

Parameters:
N_VIAS, 2, number of vehicle approaches (2..8)
TICK_DIV, 4, clk cycles per timing tick (sim default; 50_000_000 on board)
T_VERDE, 8, green duration in ticks when no request is pending
T_VERDE_MIN, 3, minimum green ticks before a pending request may cut green short (1 ≤ T_VERDE_MIN ≤ T_VERDE)
T_AMARILLO, 2, amber duration in ticks
T_ROJO, 1, all-red clearance duration in ticks
T_BLANCO, 5, pedestrian walk duration in ticks
DEB_CICLOS, 3, clk cycles pulsador must be stable high to count as a press

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
pulsador  in  1  pedestrian button, asynchronous, active-high
modo_noche  in  1  night-mode request, asynchronous level
rojo  out  N_VIAS  red lamp per approach
amarillo  out  N_VIAS  amber lamp per approach
verde  out  N_VIAS  green lamp per approach
blanco  out  1  pedestrian walk lamp
via_activa  out  $clog2(N_VIAS)  index of current/last green approach

Behaviour:
- Reset (rst=0, async):
  - state=TODO_ROJO, timer=T_ROJO, via=0, request latch=0, prescaler=0.
  - rojo=all 1s; amarillo, verde, blanco, via_activa = 0.
- Inputs: pulsador and modo_noche pass through 2-FF synchronisers.
- Tick:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - tick pulses 1 cycle when count==TICK_DIV-1.
  - Prescaler is never reset by the FSM.
- Timer:
  - Loaded with the state duration on entry.
  - Decremented on each tick; the state exits on the tick where timer==1.
  - Each state therefore lasts exactly its duration in ticks.
- Debounce:
  - Synced pulsador must be 1 for DEB_CICLOS consecutive clks, then produces a single-cycle press pulse.
  - Pulsador must return to 0 before another press is accepted.
- Request latch:
  - Set by a press in any state except BLANCO and NOCHE; presses in those states are ignored.
  - Cleared on entry to BLANCO.
  - Press and clear in the same cycle: clear wins.
- States and transitions (all transitions occur on tick):
  - TODO_ROJO
    - Exit priority: modo_noche=1 → NOCHE; else latch=1 → BLANCO; else VERDE with via = (via+1) mod N_VIAS.
    - Exception: the first TODO_ROJO after reset, or after NOCHE, goes to VERDE with via=0 without incrementing.
  - VERDE: verde[via]=1, all other rojo=1.
    - Exit to AMARILLO when T_VERDE ticks elapse.
    - Or exit early once elapsed ≥ T_VERDE_MIN and (latch=1 or modo_noche=1).
  - AMARILLO: amarillo[via]=1, others red; exit to TODO_ROJO after T_AMARILLO.
  - BLANCO: rojo=all 1s, blanco=1; exit to TODO_ROJO after T_BLANCO; via is unchanged.
  - NOCHE:
    - rojo=0, verde=0, blanco=0; amarillo=all 1s or all 0s, toggling every tick and starting at 1.
    - Exits to TODO_ROJO on the first tick where modo_noche=0.
- Outputs: registered, and change the clk cycle after the state transition.
- Safety invariant: at most one verde bit is set; verde and blanco are never 1 simultaneously.
- Lamp exclusivity: rojo|amarillo|verde is one-hot per approach in all states except NOCHE.
- via_activa: equals via in every state.

Decomposition:
- Package semaforo_pkg holds:
  - estado_t enum {TODO_ROJO, VERDE, AMARILLO, BLANCO, NOCHE};
  - the timer width constant (clog2 of the maximum duration + 1);
  - the lamp-encoding helper function.
- Sub-module antirrebote holds the 2-FF sync, the stable counter (DEB_CICLOS) and the rising-edge pulse.
- Top level: prescaler, FSM, timer, request latch, output registers.

Test Plan:
- Reset release, no inputs, defaults → after the first tick: all red for 4 clks.
  - Then verde[0] for 32 clks, amarillo[0] 8 clks, all red 4 clks, verde[1] 32 clks.
  - Then wraps back to verde[0] (via_activa 0→1→0).
- pulsador high 2 clks only → no request; high 5 clks during verde[0] at elapsed tick 1 → green ends at tick 3 (T_VERDE_MIN).
  - Then amarillo, all red, and blanco=1 for 20 clks with all rojo=1.
  - Then all red, then verde[1].
- Press during BLANCO → ignored; the next cycle goes to verde with no second BLANCO.
- modo_noche=1 mid-green → honoured at T_VERDE_MIN, then amarillo, all red, NOCHE with amarillo toggling every 4 clks.
  - modo_noche=0 → all red, then verde[0].
- rst asserted mid-AMARILLO (async, no clk edge) → outputs go immediately to all red; after release, the sequence restarts as in scenario 1.
- N_VIAS=4 build → round-robin 0,1,2,3,0; assertions check verde one-hot and verde & blanco never both set, over 2000 random-press cycles.
